// File: rtl/ctrl_pipe.sv
// Control pipeline: carries decoded control through ID/EX, EX/MEM and MEM/WB, with load-use stall and redirect flush.
// Optional performance counters are enabled by defining CTRL_PIPE_PERF_EN.
module ctrl_pipe #(
   parameter int RD_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [1:0]      id_ALUop,
   input  logic            id_ALUsrc,
   input  logic            id_LUIorAUIPC,
   input  logic [1:0]      id_Jump,
   input  logic            id_MemRead,
   input  logic            id_MemWrite,
   input  logic            id_RegWrite,
   input  logic [1:0]      id_MemToReg,
   input  logic [RD_W-1:0] id_rd,
   input  logic [RD_W-1:0] id_rs1,
   input  logic [RD_W-1:0] id_rs2,
   input  logic            ex_redirect,
   output logic [1:0]      ex_ALUop,
   output logic            ex_ALUsrc,
   output logic            ex_LUIorAUIPC,
   output logic [1:0]      ex_Jump,
   output logic            ex_MemRead,
   output logic [RD_W-1:0] ex_rd,
   output logic            mem_MemRead,
   output logic            mem_MemWrite,
   output logic            mem_RegWrite,
   output logic [1:0]      mem_MemToReg,
   output logic [RD_W-1:0] mem_rd,
   output logic            wb_RegWrite,
   output logic [1:0]      wb_MemToReg,
   output logic [RD_W-1:0] wb_rd,
   output logic            pc_write,
   output logic            ifid_write,
   output logic            ifid_flush
`ifdef CTRL_PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
`endif
);

   logic [1:0]      r_ex_ALUop;
   logic            r_ex_ALUsrc;
   logic            r_ex_LUIorAUIPC;
   logic [1:0]      r_ex_Jump;
   logic            r_ex_MemRead;
   logic            r_ex_MemWrite;
   logic            r_ex_RegWrite;
   logic [1:0]      r_ex_MemToReg;
   logic [RD_W-1:0] r_ex_rd;

   logic            r_mem_MemRead;
   logic            r_mem_MemWrite;
   logic            r_mem_RegWrite;
   logic [1:0]      r_mem_MemToReg;
   logic [RD_W-1:0] r_mem_rd;

   logic            r_wb_RegWrite;
   logic [1:0]      r_wb_MemToReg;
   logic [RD_W-1:0] r_wb_rd;

   logic w_load_use;
   logic w_flush;
   logic w_stall;
   logic w_bubble;

   // x0 is never a real dependency, so a load targeting it cannot stall
   assign w_load_use = id_valid & r_ex_MemRead & (r_ex_rd != '0) &
                       ((r_ex_rd == id_rs1) | (r_ex_rd == id_rs2));
   assign w_flush    = ex_redirect;
   assign w_stall    = w_load_use & ~w_flush;
   assign w_bubble   = w_flush | w_stall | ~id_valid;

   assign pc_write   = ~w_stall;
   assign ifid_write = ~w_stall;
   assign ifid_flush = w_flush;

   // Bubble path uses constants only, so unknown decoder outputs never enter EX
   always_ff @(posedge clk) begin
      if (rst || w_bubble) begin
         r_ex_ALUop      <= 2'b00;
         r_ex_ALUsrc     <= 1'b0;
         r_ex_LUIorAUIPC <= 1'b0;
         r_ex_Jump       <= 2'b00;
         r_ex_MemRead    <= 1'b0;
         r_ex_MemWrite   <= 1'b0;
         r_ex_RegWrite   <= 1'b0;
         r_ex_MemToReg   <= 2'b00;
         r_ex_rd         <= '0;
      end else begin
         r_ex_ALUop      <= id_ALUop;
         r_ex_ALUsrc     <= id_ALUsrc;
         r_ex_LUIorAUIPC <= id_LUIorAUIPC;
         r_ex_Jump       <= id_Jump;
         r_ex_MemRead    <= id_MemRead;
         r_ex_MemWrite   <= id_MemWrite;
         r_ex_RegWrite   <= id_RegWrite;
         r_ex_MemToReg   <= id_MemToReg;
         r_ex_rd         <= id_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_MemRead  <= 1'b0;
         r_mem_MemWrite <= 1'b0;
         r_mem_RegWrite <= 1'b0;
         r_mem_MemToReg <= 2'b00;
         r_mem_rd       <= '0;
         r_wb_RegWrite  <= 1'b0;
         r_wb_MemToReg  <= 2'b00;
         r_wb_rd        <= '0;
      end else begin
         r_mem_MemRead  <= r_ex_MemRead;
         r_mem_MemWrite <= r_ex_MemWrite;
         r_mem_RegWrite <= r_ex_RegWrite;
         r_mem_MemToReg <= r_ex_MemToReg;
         r_mem_rd       <= r_ex_rd;
         r_wb_RegWrite  <= r_mem_RegWrite;
         r_wb_MemToReg  <= r_mem_MemToReg;
         r_wb_rd        <= r_mem_rd;
      end
   end

   assign ex_ALUop      = r_ex_ALUop;
   assign ex_ALUsrc     = r_ex_ALUsrc;
   assign ex_LUIorAUIPC = r_ex_LUIorAUIPC;
   assign ex_Jump       = r_ex_Jump;
   assign ex_MemRead    = r_ex_MemRead;
   assign ex_rd         = r_ex_rd;
   assign mem_MemRead   = r_mem_MemRead;
   assign mem_MemWrite  = r_mem_MemWrite;
   assign mem_RegWrite  = r_mem_RegWrite;
   assign mem_MemToReg  = r_mem_MemToReg;
   assign mem_rd        = r_mem_rd;
   assign wb_RegWrite   = r_wb_RegWrite;
   assign wb_MemToReg   = r_wb_MemToReg;
   assign wb_rd         = r_wb_rd;

`ifdef CTRL_PIPE_PERF_EN
   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;

   // Counters wrap naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else begin
         if (w_stall) r_stall_count <= r_stall_count + 1'b1;
         if (w_flush) r_flush_count <= r_flush_count + 1'b1;
      end
   end

   assign stall_count = r_stall_count;
   assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed, table-driven bench for ctrl_pipe: reset/idle, propagation, load-use, x0 cases, redirect, reset priority.
module tb_ctrl_pipe;
   localparam int RD_W  = 5;
   localparam int CNT_W = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            id_valid;
   logic [1:0]      id_ALUop;
   logic            id_ALUsrc;
   logic            id_LUIorAUIPC;
   logic [1:0]      id_Jump;
   logic            id_MemRead;
   logic            id_MemWrite;
   logic            id_RegWrite;
   logic [1:0]      id_MemToReg;
   logic [RD_W-1:0] id_rd;
   logic [RD_W-1:0] id_rs1;
   logic [RD_W-1:0] id_rs2;
   logic            ex_redirect;
   logic [1:0]      ex_ALUop;
   logic            ex_ALUsrc;
   logic            ex_LUIorAUIPC;
   logic [1:0]      ex_Jump;
   logic            ex_MemRead;
   logic [RD_W-1:0] ex_rd;
   logic            mem_MemRead;
   logic            mem_MemWrite;
   logic            mem_RegWrite;
   logic [1:0]      mem_MemToReg;
   logic [RD_W-1:0] mem_rd;
   logic            wb_RegWrite;
   logic [1:0]      wb_MemToReg;
   logic [RD_W-1:0] wb_rd;
   logic            pc_write;
   logic            ifid_write;
   logic            ifid_flush;
`ifdef CTRL_PIPE_PERF_EN
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   ctrl_pipe #(.RD_W(RD_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_ALUop(id_ALUop), .id_ALUsrc(id_ALUsrc), .id_LUIorAUIPC(id_LUIorAUIPC),
      .id_Jump(id_Jump), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_RegWrite(id_RegWrite), .id_MemToReg(id_MemToReg),
      .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_redirect(ex_redirect),
      .ex_ALUop(ex_ALUop), .ex_ALUsrc(ex_ALUsrc), .ex_LUIorAUIPC(ex_LUIorAUIPC),
      .ex_Jump(ex_Jump), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
      .mem_RegWrite(mem_RegWrite), .mem_MemToReg(mem_MemToReg), .mem_rd(mem_rd),
      .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg), .wb_rd(wb_rd),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush)
`ifdef CTRL_PIPE_PERF_EN
      , .stall_count(stall_count), .flush_count(flush_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] aluop; logic alusrc; logic lui; logic [1:0] jmp;
      logic mr; logic mw; logic rw; logic [1:0] mtr;
      logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
   } id_t;

   typedef struct packed {
      logic pcw; logic ifl;
      logic [1:0] ex_aluop; logic ex_src; logic ex_lui; logic [1:0] ex_jump; logic ex_mr; logic [4:0] ex_rd;
      logic mem_mr; logic mem_mw; logic mem_rw; logic [1:0] mem_mtr; logic [4:0] mem_rd;
      logic wb_rw; logic [1:0] wb_mtr; logic [4:0] wb_rd;
   } exp_t;

   typedef struct packed {
      logic v; id_t id; logic redir; exp_t e;
   } vec_t;

   localparam int N_VEC = 18;
   vec_t tbl [N_VEC];

   function automatic id_t mk_id(int aluop, int src, int lui, int jmp, int mr, int mw,
                                 int rw, int mtr, int rd, int rs1, int rs2);
      id_t r;
      r.aluop = 2'(aluop); r.alusrc = 1'(src); r.lui = 1'(lui); r.jmp = 2'(jmp);
      r.mr = 1'(mr); r.mw = 1'(mw); r.rw = 1'(rw); r.mtr = 2'(mtr);
      r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2);
      return r;
   endfunction

   function automatic exp_t mk_exp(int pcw, int ifl,
                                   int ex_aluop, int ex_src, int ex_lui, int ex_jump, int ex_mr, int ex_rd,
                                   int mem_mr, int mem_mw, int mem_rw, int mem_mtr, int mem_rd,
                                   int wb_rw, int wb_mtr, int wb_rd);
      exp_t r;
      r.pcw = 1'(pcw); r.ifl = 1'(ifl);
      r.ex_aluop = 2'(ex_aluop); r.ex_src = 1'(ex_src); r.ex_lui = 1'(ex_lui);
      r.ex_jump = 2'(ex_jump); r.ex_mr = 1'(ex_mr); r.ex_rd = 5'(ex_rd);
      r.mem_mr = 1'(mem_mr); r.mem_mw = 1'(mem_mw); r.mem_rw = 1'(mem_rw);
      r.mem_mtr = 2'(mem_mtr); r.mem_rd = 5'(mem_rd);
      r.wb_rw = 1'(wb_rw); r.wb_mtr = 2'(wb_mtr); r.wb_rd = 5'(wb_rd);
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      chk({tag, " pc_write"},      32'(pc_write),      32'(e.pcw));
      chk({tag, " ifid_write"},    32'(ifid_write),    32'(e.pcw));
      chk({tag, " ifid_flush"},    32'(ifid_flush),    32'(e.ifl));
      chk({tag, " ex_ALUop"},      32'(ex_ALUop),      32'(e.ex_aluop));
      chk({tag, " ex_ALUsrc"},     32'(ex_ALUsrc),     32'(e.ex_src));
      chk({tag, " ex_LUIorAUIPC"}, 32'(ex_LUIorAUIPC), 32'(e.ex_lui));
      chk({tag, " ex_Jump"},       32'(ex_Jump),       32'(e.ex_jump));
      chk({tag, " ex_MemRead"},    32'(ex_MemRead),    32'(e.ex_mr));
      chk({tag, " ex_rd"},         32'(ex_rd),         32'(e.ex_rd));
      chk({tag, " mem_MemRead"},   32'(mem_MemRead),   32'(e.mem_mr));
      chk({tag, " mem_MemWrite"},  32'(mem_MemWrite),  32'(e.mem_mw));
      chk({tag, " mem_RegWrite"},  32'(mem_RegWrite),  32'(e.mem_rw));
      chk({tag, " mem_MemToReg"},  32'(mem_MemToReg),  32'(e.mem_mtr));
      chk({tag, " mem_rd"},        32'(mem_rd),        32'(e.mem_rd));
      chk({tag, " wb_RegWrite"},   32'(wb_RegWrite),   32'(e.wb_rw));
      chk({tag, " wb_MemToReg"},   32'(wb_MemToReg),   32'(e.wb_mtr));
      chk({tag, " wb_rd"},         32'(wb_rd),         32'(e.wb_rd));
   endtask

   task automatic drive_id(input logic v, input id_t id, input logic redir);
      id_valid      = v;
      id_ALUop      = id.aluop;
      id_ALUsrc     = id.alusrc;
      id_LUIorAUIPC = id.lui;
      id_Jump       = id.jmp;
      id_MemRead    = id.mr;
      id_MemWrite   = id.mw;
      id_RegWrite   = id.rw;
      id_MemToReg   = id.mtr;
      id_rd         = id.rd;
      id_rs1        = id.rs1;
      id_rs2        = id.rs2;
      ex_redirect   = redir;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      id_t r_ty, ld7, use7, ld0, x0u, n8, jal, st, jnk;
      exp_t zero_e;

      //                aluop src lui jmp mr mw rw mtr rd rs1 rs2
      r_ty = mk_id(2, 0, 0, 0, 0, 0, 1, 1,  5, 1, 2);
      ld7  = mk_id(0, 1, 0, 0, 1, 0, 1, 2,  7, 3, 0);
      use7 = mk_id(2, 0, 0, 0, 0, 0, 1, 1,  9, 4, 7);
      ld0  = mk_id(0, 1, 0, 0, 1, 0, 1, 2,  0, 3, 0);
      x0u  = mk_id(2, 0, 1, 0, 0, 0, 1, 1, 10, 0, 6);
      n8   = mk_id(2, 0, 0, 0, 0, 0, 1, 1, 11, 8, 9);
      jal  = mk_id(0, 0, 0, 1, 0, 0, 1, 3,  1, 0, 0);
      st   = mk_id(0, 1, 0, 0, 0, 1, 0, 0,  0, 2, 3);
      jnk  = mk_id(3, 1, 1, 3, 1, 1, 1, 3, 31, 7, 7);
      zero_e = mk_exp(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      //                         pcw ifl | ex: aluop src lui jmp mr rd | mem: mr mw rw mtr rd | wb: rw mtr rd
      tbl[0]  = '{1'b1, r_ty, 1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0)};
      tbl[1]  = '{1'b0, jnk,  1'b0, mk_exp(1, 0, 2, 0, 0, 0, 0, 5,  0, 0, 0, 0, 0,  0, 0, 0)};
      tbl[2]  = '{1'b0, jnk,  1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 5,  0, 0, 0)};
      tbl[3]  = '{1'b1, ld7,  1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 5)};
      tbl[4]  = '{1'b1, use7, 1'b0, mk_exp(0, 0, 0, 1, 0, 0, 1, 7,  0, 0, 0, 0, 0,  0, 0, 0)};
      tbl[5]  = '{1'b1, use7, 1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 2, 7,  0, 0, 0)};
      tbl[6]  = '{1'b1, ld0,  1'b0, mk_exp(1, 0, 2, 0, 0, 0, 0, 9,  0, 0, 0, 0, 0,  1, 2, 7)};
      tbl[7]  = '{1'b1, x0u,  1'b0, mk_exp(1, 0, 0, 1, 0, 0, 1, 0,  0, 0, 1, 1, 9,  0, 0, 0)};
      tbl[8]  = '{1'b1, ld7,  1'b0, mk_exp(1, 0, 2, 0, 1, 0, 0, 10, 1, 0, 1, 2, 0,  1, 1, 9)};
      tbl[9]  = '{1'b1, n8,   1'b0, mk_exp(1, 0, 0, 1, 0, 0, 1, 7,  0, 0, 1, 1, 10, 1, 2, 0)};
      tbl[10] = '{1'b1, jal,  1'b0, mk_exp(1, 0, 2, 0, 0, 0, 0, 11, 1, 0, 1, 2, 7,  1, 1, 10)};
      tbl[11] = '{1'b1, st,   1'b1, mk_exp(1, 1, 0, 0, 0, 1, 0, 1,  0, 0, 1, 1, 11, 1, 2, 7)};
      tbl[12] = '{1'b0, jnk,  1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 1,  1, 1, 11)};
      tbl[13] = '{1'b1, ld7,  1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 3, 1)};
      tbl[14] = '{1'b1, use7, 1'b1, mk_exp(1, 1, 0, 1, 0, 0, 1, 7,  0, 0, 0, 0, 0,  0, 0, 0)};
      tbl[15] = '{1'b1, st,   1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 1, 2, 7,  0, 0, 0)};
      tbl[16] = '{1'b0, jnk,  1'b0, mk_exp(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0,  1, 2, 7)};
      tbl[17] = '{1'b0, jnk,  1'b0, mk_exp(1, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0, 0, 0)};

      // Reset held for two edges with a live-looking bundle on the decoder inputs
      rst = 1'b1;
      drive_id(1'b1, jnk, 1'b0);
      next_cycle();
      @(negedge clk);
      check_outputs("reset", zero_e);
      next_cycle();
      rst = 1'b0;
      drive_id(1'b0, jnk, 1'b0);
      for (int k = 0; k < 5; k++) begin
         if (k != 0) next_cycle();
         @(negedge clk);
         check_outputs($sformatf("idle%0d", k), zero_e);
      end
`ifdef CTRL_PIPE_PERF_EN
      chk("idle stall_count", 32'(stall_count), 32'd0);
      chk("idle flush_count", 32'(flush_count), 32'd0);
`endif

      for (int i = 0; i < N_VEC; i++) begin
         next_cycle();
         drive_id(tbl[i].v, tbl[i].id, tbl[i].redir);
         @(negedge clk);
         check_outputs($sformatf("row%0d", i), tbl[i].e);
`ifdef CTRL_PIPE_PERF_EN
         if (i == 5)  chk("stall_count after load-use", 32'(stall_count), 32'd1);
         if (i == 12) chk("flush_count after redirect", 32'(flush_count), 32'd1);
`endif
      end
`ifdef CTRL_PIPE_PERF_EN
      chk("stall_count after flush+load-use", 32'(stall_count), 32'd1);
      chk("flush_count after flush+load-use", 32'(flush_count), 32'd2);
`endif

      // Reset while a store sits in MEM and a redirect plus valid bundle are presented
      rst = 1'b1;
      drive_id(1'b1, r_ty, 1'b1);
      next_cycle();
      rst = 1'b0;
      drive_id(1'b0, jnk, 1'b0);
      @(negedge clk);
      check_outputs("post-reset", zero_e);
`ifdef CTRL_PIPE_PERF_EN
      chk("post-reset stall_count", 32'(stall_count), 32'd0);
      chk("post-reset flush_count", 32'(flush_count), 32'd0);
`endif
      next_cycle();
      @(negedge clk);
      check_outputs("post-reset idle", zero_e);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
